// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and constants for the sequential restoring divider.
//           SEQ_DIVIDER_SIGNED_EN adds the FIXUP state for two's-complement mode.
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int          c_default_width = 8;
    localparam logic [63:0] c_dbz_quotient  = '1;

`ifdef SEQ_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } div_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2
    } div_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One combinational radix-2 restoring step: shift, trial subtract,
//           select partial remainder and append the quotient bit.
// Revision: 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic [WIDTH-1:0] o_shreg_next
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // rem < divisor always holds, so the WIDTH+1 bit difference cannot overflow
    // and its MSB is a true sign bit.
    assign w_shifted    = {i_rem, i_shreg[WIDTH-1]};
    assign w_trial      = w_shifted - {1'b0, i_divisor};
    assign o_rem_next   = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_shreg_next = {i_shreg[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle radix-2 restoring divider, one quotient bit per clock.
//           Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_dbz_q = c_dbz_quotient[WIDTH-1:0];

    div_state_t         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_shreg_next;
    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic r_q_neg;
    logic r_r_neg;

    assign w_dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    assign w_dividend_mag = dividend;
    assign w_divisor_mag  = divisor;
`endif

    div_step #(
        .WIDTH        (WIDTH)
    ) u_div_step (
        .i_rem        (r_rem),
        .i_shreg      (r_shreg),
        .i_divisor    (r_divisor),
        .o_rem_next   (w_rem_next),
        .o_shreg_next (w_shreg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_shreg     <= '0;
            r_divisor   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            // Division by zero skips CALC and answers next cycle.
                            quotient    <= c_dbz_q;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            r_count     <= c_cnt_w'(WIDTH);
                            r_rem       <= '0;
                            r_shreg     <= w_dividend_mag;
                            r_divisor   <= w_divisor_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            r_q_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_r_neg     <= dividend[WIDTH-1];
`endif
                            r_state     <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_next;
                    r_shreg <= w_shreg_next;
                    r_count <= r_count - c_cnt_w'(1);
                    if (r_count == c_cnt_w'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_state   <= FIXUP;
`else
                        quotient  <= w_shreg_next;
                        remainder <= w_rem_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= DONE;
`endif
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIXUP: begin
                    // Truncation toward zero: remainder follows the dividend's sign.
                    quotient  <= r_q_neg ? -r_shreg : r_shreg;
                    remainder <= r_r_neg ? -r_rem   : r_rem;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= DONE;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
